muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the single-cycle `alu` in the execute stage. It implements signed and unsigned multiply and divide on WIDTH-bit operands, producing a 2·WIDTH-bit result split into `hi` and `lo`. Execute stalls on `busy` and resumes on the one-cycle `done` pulse. `flush` cancels an in-flight operation on exception or pipeline flush.

## Interface
- `WIDTH`, default 32: operand width; legal values are 2 or greater. `hi`, `lo` and `wdata` are also WIDTH bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request an operation. Sampled only when `busy`=0.
- `op` input 2: operation select. 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- `opr1` input WIDTH: multiplicand or dividend. Captured on the accepted `start`.
- `opr2` input WIDTH: multiplier or divisor. Captured on the accepted `start`.
- `flush` input 1: abort any in-flight operation.
- `hi_we` input 1: write `wdata` into HI (MTHI).
- `lo_we` input 1: write `wdata` into LO (MTLO).
- `wdata` input WIDTH: write data for `hi_we` / `lo_we`.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse; `hi`/`lo` hold the new result in this same cycle.
- `hi` output WIDTH: HI register. Holds the product high half or the remainder.
- `lo` output WIDTH: LO register. Holds the product low half or the quotient.

## Operation
- States:
  - IDLE: waiting for `start`.
  - CALC: iterating; an iteration counter of $clog2(WIDTH)+1 bits counts WIDTH steps.
  - DONE: one cycle with `done`=1.
- Transitions:
  - IDLE → CALC when `start`=1 and `flush`=0.
  - CALC → DONE after the WIDTH-th iteration.
  - DONE → IDLE unconditionally.
  - Any state → IDLE on `flush`.
- `busy` = (state ≠ IDLE). `start` while busy is ignored; its operands are not captured.
- Signed operations iterate on operand magnitudes, then apply a sign fix when writing HI/LO:
  - product sign = opr1[W-1] ^ opr2[W-1];
  - quotient sign = opr1[W-1] ^ opr2[W-1];
  - remainder takes the dividend's sign.
- Multiply: shift-add, one multiplier bit per cycle.
- Divide: restoring, one quotient bit per cycle.
- Divide by zero (opr2 = 0, div or divu): no iteration; go IDLE → DONE directly with `lo` = all ones and `hi` = opr1.
- Signed overflow, most-negative ÷ −1: `lo` = most-negative value, `hi` = 0. No trap is raised.
- HI/LO change only on completion (entry into DONE) or on an MTHI/MTLO write.
- `hi_we` / `lo_we` are honoured only when `busy`=0.
  - A write in the same cycle as an accepted `start` takes effect; the later result then overwrites it.
- `flush`:
  - takes priority over `start`, completion and writes in the same cycle;
  - leaves HI/LO unchanged;
  - produces no `done`.
- Reset: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.

## Timing
- Cycle 0 is the cycle in which `start` is accepted.
- Iterative operation:
  - cycles 1..WIDTH: CALC, `busy`=1;
  - cycle WIDTH+1: DONE, `done`=1, `busy`=1, result visible;
  - cycle WIDTH+2: IDLE, and a new `start` is accepted.
- Divide by zero, or multiply with the fast-multiply option enabled (see Configuration): DONE in cycle 1 and IDLE in cycle 2.
- `flush` asserted in cycle k, with the unit busy: IDLE in cycle k+1 and `busy`=0 in cycle k+1.
- `rst` overrides everything in the same edge, including mid-operation. No partial result is written.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - Defined: mult/multu use a single registered WIDTH×WIDTH multiply. The unit goes IDLE → DONE with `done` in cycle 1, and the multiply never enters CALC.
  - Undefined: the iterative shift-add path is used, with `done` in cycle WIDTH+1.
  - Division is iterative in both cases.

## Test plan
- Unsigned multiply: multu 0xFFFFFFFF × 0xFFFFFFFF → `done` in cycle 33 (cycle 1 with fast multiply), `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed multiply: mult 0xFFFFFFFD (−3) × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- Signed divide: div 0xFFFFFFF9 (−7) ÷ 2 → `done` in cycle 33, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- Divide edge cases:
  - divu 0x1234 ÷ 0 → `done` in cycle 1, `lo`=0xFFFFFFFF, `hi`=0x1234;
  - div 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Flush: divu started, then `flush` in cycle 10 → `busy`=0 in cycle 11, no `done`, HI/LO keep their prior values. A `start` in cycle 11 is accepted.
- Write and ignored start:
  - `hi_we` with `wdata`=0xA5A5A5A5 while idle → `hi`=0xA5A5A5A5 next cycle;
  - a second `start` during CALC is ignored, and only one `done` is seen.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Signed and unsigned multiply (shift-add) and divide (restoring), one bit per cycle,
// iterating on operand magnitudes with a sign fix applied when HI/LO are written.
// Optional feature macro MULDIV_FAST_MUL_EN: when defined, mult/multu complete through
// a single registered WIDTH x WIDTH multiply and never enter CALC.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opr1,
    input  logic [WIDTH-1:0] opr2,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state, state_d;

    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     acc;     // partial product high part / partial remainder
    logic [WIDTH-1:0]   low;     // multiplier being consumed / quotient being built
    logic [WIDTH-1:0]   dvs;     // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_q;   // negate product or quotient on completion
    logic               neg_r;   // negate remainder on completion

    logic               signed_op;
    logic               opr1_neg;
    logic               opr2_neg;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               div_zero;
    logic               fast_mul;
    logic               last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH:0]     step_acc;
    logic [WIDTH-1:0]   step_low;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Operand decode: signedness, magnitudes and the divide-by-zero shortcut
    always_comb begin
        signed_op = ~op[0];
        opr1_neg  = signed_op & opr1[WIDTH-1];
        opr2_neg  = signed_op & opr2[WIDTH-1];
        mag1      = opr1_neg ? ({WIDTH{1'b0}} - opr1) : opr1;
        mag2      = opr2_neg ? ({WIDTH{1'b0}} - opr2) : opr2;
        div_zero  = op[1] & (opr2 == {WIDTH{1'b0}});
`ifdef MULDIV_FAST_MUL_EN
        fast_mul  = ~op[1];
`else
        fast_mul  = 1'b0;
`endif
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    // One iteration of shift-add multiply or restoring divide, plus the signed result fix
    always_comb begin
        mul_sum   = acc + (low[0] ? {1'b0, dvs} : {(WIDTH+1){1'b0}});
        div_shift = {acc[WIDTH-1:0], low[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, dvs};
        if (is_div) begin
            step_acc = div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
            step_low = {low[WIDTH-2:0], ~div_diff[WIDTH+1]};
        end else begin
            step_acc = {1'b0, mul_sum[WIDTH:1]};
            step_low = {mul_sum[0], low[WIDTH-1:1]};
        end
        prod     = {step_acc[WIDTH-1:0], step_low};
        prod_fix = neg_q ? ({(2*WIDTH){1'b0}} - prod) : prod;
        if (is_div) begin
            res_lo = neg_q ? ({WIDTH{1'b0}} - step_low) : step_low;
            res_hi = neg_r ? ({WIDTH{1'b0}} - step_acc[WIDTH-1:0]) : step_acc[WIDTH-1:0];
        end else begin
            res_lo = prod_fix[WIDTH-1:0];
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_d = (div_zero || fast_mul) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (last_iter) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Registered status outputs follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d != S_IDLE);
            done <= (state_d == S_DONE);
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    logic [2*WIDTH-1:0] fast_fix;

    // Single-cycle magnitude multiply with sign fix
    always_comb begin
        fast_prod = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
        fast_fix  = (opr1_neg ^ opr2_neg) ? ({(2*WIDTH){1'b0}} - fast_prod) : fast_prod;
    end
`endif

    // Datapath, iteration counter and HI/LO; a flush freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            low    <= '0;
            dvs    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        cnt    <= '0;
                        acc    <= '0;
                        is_div <= op[1];
                        neg_q  <= opr1_neg ^ opr2_neg;
                        neg_r  <= opr1_neg;
                        low    <= op[1] ? mag1 : mag2;
                        dvs    <= op[1] ? mag2 : mag1;
                        if (div_zero) begin
                            hi <= opr1;
                            lo <= {WIDTH{1'b1}};
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (fast_mul) begin
                            hi <= fast_fix[2*WIDTH-1:WIDTH];
                            lo <= fast_fix[WIDTH-1:0];
                        end
`endif
                    end
                end
                S_CALC: begin
                    acc <= step_acc;
                    low <= step_low;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected results (value and
// completion cycle) produced by an arithmetic reference model, checked by a monitor
// on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .opr1  (opr1),
        .opr2  (opr2),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    int          n_push = 0;
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: plain integer arithmetic on the architectural rules
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb_;
        longint unsigned ua, ub, up;
        int ia, ib;
        e.cyc = 0;
        case (o)
            2'd0: begin
                sa = $signed(a);
                sb_ = $signed(b);
                up = longint'(sa * sb_);
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            2'd1: begin
                ua = {32'h0, a};
                ub = {32'h0, b};
                up = ua * ub;
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            2'd2: begin
                if (b == 32'h0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'h0; e.lo = 32'h8000_0000;
                end else begin
                    ia = a; ib = b;
                    e.lo = ia / ib;
                    e.hi = ia % ib;
                end
            end
            default: begin
                if (b == 32'h0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [31:0] b);
        if (o[1] && b == 32'h0) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[1]) return 1;
`endif
        return 33;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("hi", {32'h0, hi}, {32'h0, e.hi});
                check("lo", {32'h0, lo}, {32'h0, e.lo});
            end
        end
    end

    // Drives start at a negedge (cycle 0) and returns at the negedge of cycle 1
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        e = model(o, a, b);
        e.cyc = cyc + latency(o, b);
        if (push) begin
            sb.push_back(e);
            n_push++;
            model_hi = e.hi;
            model_lo = e.lo;
        end
        start = 1'b1; op = o; opr1 = a; opr2 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        n_checks++;
        $display("FAIL idle_timeout: got busy=1 expected busy=0 within 200 cycles (cycle %0d)", cyc);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        issue(o, a, b, 1'b1);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev_lo;
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        rst = 1'b1; start = 1'b0; op = 2'd0; opr1 = '0; opr2 = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_hi", {32'h0, hi}, 64'h0);
        check("reset_lo", {32'h0, lo}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005);
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op(2'd3, 32'h0000_1234, 32'h0000_0000);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'd2, 32'h0000_0007, 32'h0000_0000);

        // MTHI / MTLO while idle
        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        model_hi = 32'hA5A5_A5A5;
        check("mthi", {32'h0, hi}, {32'h0, model_hi});
        lo_we = 1'b1; wdata = 32'h5A5A_0F0F;
        @(negedge clk);
        lo_we = 1'b0;
        model_lo = 32'h5A5A_0F0F;
        check("mtlo", {32'h0, lo}, {32'h0, model_lo});

        // Write in the same cycle as an accepted start, later overwritten by the result
        hi_we = 1'b1; wdata = 32'h0000_1111;
        issue(2'd3, 32'd100, 32'd7, 1'b1);
        hi_we = 1'b0;
        check("write_with_start", {32'h0, hi}, 64'h1111);
        wait_idle();

        // Flush at idle beats start and write
        flush = 1'b1; start = 1'b1; op = 2'd3; opr1 = 32'd9; opr2 = 32'd0;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        flush = 1'b0; start = 1'b0; hi_we = 1'b0;
        check("flush_idle_busy", {63'h0, busy}, 64'h0);
        check("flush_idle_hi", {32'h0, hi}, {32'h0, model_hi});

        // Flush in cycle 10 of a divide, then a start in cycle 11
        issue(2'd3, 32'hFFFF_0000, 32'd3, 1'b0);
        check("calc_busy", {63'h0, busy}, 64'h1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'h0, busy}, 64'h0);
        check("flush_hi", {32'h0, hi}, {32'h0, model_hi});
        check("flush_lo", {32'h0, lo}, {32'h0, model_lo});
        issue(2'd3, 32'd1000, 32'd33, 1'b1);
        wait_idle();

        // Start and write during CALC are ignored
        prev_lo = model_lo;
        issue(2'd0, 32'h0001_0003, 32'hFFFF_FF00, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd3; opr1 = 32'd55; opr2 = 32'd0;
        lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        check("busy_write_ignored", {32'h0, lo}, {32'h0, prev_lo});
        wait_idle();

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_op(ro, ra, rb);
        end

        repeat (3) @(negedge clk);
        check("done_count", 64'(done_cnt), 64'(n_push));
        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
